// File: rtl/cpu_types_pkg.sv
// Shared CPU types: BTB entry layout, 2-bit branch counter encoding and helpers.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        STRONG_NT,
        WEAK_NT,
        WEAK_T,
        STRONG_T
    } bpred_ctr_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        bpred_ctr_t  ctr;
    } btb_entry_t;

    localparam bpred_ctr_t BTB_ALLOC_CTR = WEAK_T;

    localparam btb_entry_t BTB_ENTRY_RESET = '{
        valid:  1'b0,
        tag:    30'd0,
        target: 32'd0,
        ctr:    WEAK_NT
    };

    // Tag is kept right-aligned in a 30-bit field so one struct fits any table size.
    function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

    function automatic bpred_ctr_t ctr_step(input bpred_ctr_t c, input logic taken);
        if (taken)
            return (c == STRONG_T) ? STRONG_T : bpred_ctr_t'(c + 2'd1);
        else
            return (c == STRONG_NT) ? STRONG_NT : bpred_ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// BTB entry storage: async-reset flops, fetch and execute read ports, one write port.
module btb_table
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] ft_idx,
    output btb_entry_t       ft_entry,
    input  logic [IDX_W-1:0] ex_idx,
    output btb_entry_t       ex_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    btb_entry_t mem [ENTRIES];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= BTB_ENTRY_RESET;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // Reads see pre-write contents; no same-cycle bypass.
    assign ft_entry = mem[ft_idx];
    assign ex_entry = mem[ex_idx];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch lookup, EX resolution and training.
// Define BPRED_STATS_EN to add saturating branch/mispredict statistics outputs.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_ft,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        resolve_en,
    input  logic        stall_ex,
    input  logic [31:0] pc_ex,
    input  logic        taken_ex,
    input  logic [31:0] target_ex,
    input  logic        pred_taken_ex,
    input  logic [31:0] pred_target_ex,
    output logic        branch_mispredict,
    output logic [31:0] correct_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [IDX_W-1:0] idx_ft;
    logic [IDX_W-1:0] idx_ex;
    btb_entry_t       ft_entry;
    btb_entry_t       ex_entry;
    btb_entry_t       wr_entry;
    logic             wr_en;
    logic             hit_ft;
    logic             hit_ex;
    logic             act;

    assign idx_ft = pc_ft[IDX_W+1:2];
    assign idx_ex = pc_ex[IDX_W+1:2];

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .CLK      (CLK),
        .RST      (RST),
        .ft_idx   (idx_ft),
        .ft_entry (ft_entry),
        .ex_idx   (idx_ex),
        .ex_entry (ex_entry),
        .wr_en    (wr_en),
        .wr_idx   (idx_ex),
        .wr_entry (wr_entry)
    );

    assign hit_ft = ft_entry.valid && (ft_entry.tag == btb_tag(pc_ft, IDX_W));
    assign hit_ex = ex_entry.valid && (ex_entry.tag == btb_tag(pc_ex, IDX_W));

    assign predict_taken  = hit_ft & ft_entry.ctr[1];
    assign predict_target = predict_taken ? ft_entry.target : pc_ft + 32'd4;

    assign act = resolve_en & ~stall_ex;

    assign branch_mispredict = act & ((taken_ex != pred_taken_ex) |
                               (taken_ex & (target_ex != pred_target_ex)));

    assign correct_pc = taken_ex ? target_ex : pc_ex + 32'd4;

    // Hits train in place; only taken misses allocate.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (act) begin
            if (hit_ex) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_step(ex_entry.ctr, taken_ex);
                if (taken_ex)
                    wr_entry.target = target_ex;
            end else if (taken_ex) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = btb_tag(pc_ex, IDX_W);
                wr_entry.target = target_ex;
                wr_entry.ctr    = BTB_ALLOC_CTR;
            end
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (act && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (branch_mispredict && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random checks of branch_predictor against a table-level reference model.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] pc_ft = 32'h40;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        resolve_en = 1'b0;
    logic        stall_ex = 1'b0;
    logic [31:0] pc_ex = 32'h0;
    logic        taken_ex = 1'b0;
    logic [31:0] target_ex = 32'h0;
    logic        pred_taken_ex = 1'b0;
    logic [31:0] pred_target_ex = 32'h0;
    logic        branch_mispredict;
    logic [31:0] correct_pc;
`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.BTB_ENTRIES(16)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .pc_ft             (pc_ft),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .resolve_en        (resolve_en),
        .stall_ex          (stall_ex),
        .pc_ex             (pc_ex),
        .taken_ex          (taken_ex),
        .target_ex         (target_ex),
        .pred_taken_ex     (pred_taken_ex),
        .pred_target_ex    (pred_target_ex),
        .branch_mispredict (branch_mispredict),
        .correct_pc        (correct_pc)
`ifdef BPRED_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one record per index, counter held as an integer 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      s_br;
    longint      s_mp;

    bit          r_pt;
    logic [31:0] r_ptgt;
    bit          r_mp;
    logic [31:0] r_cpc;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
            m_ctr[i]   = 1;
        end
        s_br = 0;
        s_mp = 0;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic void m_pred(input logic [31:0] pc, output bit pt,
                                   output logic [31:0] tg);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == (pc >> 6));
        pt  = hit && (m_ctr[i] >= 2);
        tg  = pt ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit tk,
                                     input logic [31:0] tg);
        int i;
        i = idx_of(pc);
        if (m_valid[i] && m_tag[i] == (pc >> 6)) begin
            m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (tk) m_tgt[i] = tg;
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc >> 6;
            m_tgt[i]   = tg;
            m_ctr[i]   = 2;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] ft, input bit en, input bit st,
                        input logic [31:0] ex, input bit tk,
                        input logic [31:0] tg, input bit ptk,
                        input logic [31:0] ptg);
        bit          ept;
        logic [31:0] etg;
        bit          act;
        bit          emp;
        @(negedge CLK);
        pc_ft          = ft;
        resolve_en     = en;
        stall_ex       = st;
        pc_ex          = ex;
        taken_ex       = tk;
        target_ex      = tg;
        pred_taken_ex  = ptk;
        pred_target_ex = ptg;
        #1;
        m_pred(ft, ept, etg);
        act = en && !st;
        emp = act && ((tk != ptk) || (tk && tg != ptg));
        r_pt   = predict_taken;
        r_ptgt = predict_target;
        r_mp   = branch_mispredict;
        r_cpc  = correct_pc;
        chk("predict_taken", 32'(predict_taken), 32'(ept));
        chk("predict_target", predict_target, etg);
        chk("branch_mispredict", 32'(branch_mispredict), 32'(emp));
        chk("correct_pc", correct_pc, tk ? tg : ex + 32'd4);
`ifdef BPRED_STATS_EN
        chk("stat_branches", stat_branches, 32'(s_br));
        chk("stat_mispredicts", stat_mispredicts, 32'(s_mp));
`endif
        @(posedge CLK);
        if (!RST && act) begin
            s_br++;
            if (emp) s_mp++;
            m_update(ex, tk, tg);
        end
    endtask

    task automatic look(input logic [31:0] ft);
        step(ft, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          pt;
        logic [31:0] ptg;
        logic [31:0] ex;
        logic [31:0] tg;
        bit          tk;

        m_reset();
        #2;
        chk("rst_predict_taken", 32'(predict_taken), 32'd0);
        chk("rst_predict_target", predict_target, 32'h44);
        chk("rst_mispredict", 32'(branch_mispredict), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        step(32'h40, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
        chk("t2_mispredict", 32'(r_mp), 32'd1);
        chk("t2_correct_pc", r_cpc, 32'h80);
        look(32'h40);
        chk("t2_lookup_taken", 32'(r_pt), 32'd1);
        chk("t2_lookup_target", r_ptgt, 32'h80);

        step(32'h40, 1, 0, 32'h40, 0, 32'h0, 1, 32'h80);
        chk("t3_first_mispredict", 32'(r_mp), 32'd1);
        chk("t3_first_correct_pc", r_cpc, 32'h44);
        step(32'h40, 1, 0, 32'h40, 0, 32'h0, 0, 32'h44);
        chk("t3_second_mispredict", 32'(r_mp), 32'd0);
        look(32'h40);
        chk("t3_lookup_not_taken", 32'(r_pt), 32'd0);
        step(32'h40, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
        look(32'h40);
        chk("t3_strong_nt_to_weak_nt", 32'(r_pt), 32'd0);

        step(32'h40, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
        look(32'h40);
        chk("t4_trained", 32'(r_pt), 32'd1);
        step(32'h40, 1, 0, 32'h80, 1, 32'hC0, 0, 32'h84);
        look(32'h40);
        chk("t4_alias_evicted", 32'(r_pt), 32'd0);
        chk("t4_alias_evicted_tgt", r_ptgt, 32'h44);
        look(32'h80);
        chk("t4_alias_taken", 32'(r_pt), 32'd1);
        chk("t4_alias_target", r_ptgt, 32'hC0);

        step(32'h80, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        chk("t5_stall_no_mispredict", 32'(r_mp), 32'd0);
        look(32'h80);
        chk("t5_stall_table_kept", r_ptgt, 32'hC0);
        step(32'h100, 1, 0, 32'h100, 1, 32'h200, 0, 32'h104);
        chk("t5_unstall_mispredict", 32'(r_mp), 32'd1);
        look(32'h100);
        chk("t5_unstall_target", r_ptgt, 32'h200);

        for (int n = 0; n < 400; n++) begin
            ex = ((32'($urandom) % 3) << 6) | ((32'($urandom) % 4) << 2);
            tk = 1'($urandom);
            tg = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 3 != 0) begin
                m_pred(ex, pt, ptg);
            end else begin
                pt  = 1'($urandom);
                ptg = pt ? tg : ex + 32'd4;
            end
            step(((32'($urandom) % 3) << 6) | ((32'($urandom) % 4) << 2),
                 ($urandom % 5) != 0, ($urandom % 5) == 0, ex, tk, tg, pt, ptg);
            if (n == 200) begin
                @(negedge CLK);
                resolve_en = 1'b0;
                #2 RST = 1'b1;
                #1;
                m_reset();
                m_pred(pc_ft, pt, ptg);
                chk("mid_reset_predict_taken", 32'(predict_taken), 32'(pt));
                chk("mid_reset_predict_target", predict_target, ptg);
                @(negedge CLK);
                RST = 1'b0;
            end
        end

`ifdef BPRED_STATS_EN
        @(negedge CLK);
        resolve_en = 1'b0;
        RST = 1'b1;
        m_reset();
        @(negedge CLK);
        RST = 1'b0;
        step(32'h0, 1, 0, 32'h10, 1, 32'h90, 0, 32'h14);
        step(32'h0, 1, 0, 32'h10, 1, 32'h90, 1, 32'h90);
        step(32'h0, 1, 1, 32'h20, 1, 32'hA0, 0, 32'h24);
        step(32'h0, 1, 0, 32'h20, 0, 32'h0, 0, 32'h24);
        step(32'h0, 1, 0, 32'h10, 0, 32'h0, 1, 32'h90);
        step(32'h0, 1, 0, 32'h30, 0, 32'h0, 0, 32'h34);
        @(negedge CLK);
        resolve_en = 1'b0;
        #1;
        chk("stats_branches_5", stat_branches, 32'd5);
        chk("stats_mispredicts_2", stat_mispredicts, 32'd2);
        #2 RST = 1'b1;
        #1;
        chk("stats_reset_branches", stat_branches, 32'd0);
        chk("stats_reset_mispredicts", stat_mispredicts, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
